// File: rtl/memory_stage_pkg.sv
// Shared pipeline types for the MEM stage: control encoding, stage payloads
// and the MEM-stage FSM state.
package memory_stage_pkg;

    typedef logic [63:0] u64;
    typedef logic [4:0]  u5;
    typedef logic [2:0]  u3;

    typedef enum logic [1:0] {
        MemNone  = 2'b00,
        MemLoad  = 2'b01,
        MemStore = 2'b10,
        MemRsvd  = 2'b11
    } mem_rw_t;

    // memSize holds the load/store funct3: [1:0] log2 bytes, [2] unsigned load.
    typedef struct packed {
        logic    reg_write;
        mem_rw_t memRw;
        u3       memSize;
    } control_t;

    typedef struct packed {
        logic     valid;
        u64       pc;
        u64       alu_out;
        u64       srcb;
        u64       sextimm;
        u64       target;
        u5        dst;
        control_t ctl;
    } execute_data_t;

    typedef struct packed {
        logic     valid;
        u64       pc;
        u64       alu_out;
        u64       rd;
        u64       sextimm;
        u64       target;
        u5        dst;
        control_t ctl;
    } memory_data_t;

    typedef enum logic [1:0] {
        StEmpty,
        StReq,
        StWait,
        StFull
    } mstate_t;

    function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return off[0];
            2'd2:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_mem_align.sv
// Byte-lane alignment for a 64-bit data bus: store strobe/data shifting and
// load extraction with sign or zero extension. Purely combinational.
module memory_stage_mem_align (
    input  logic [2:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic        is_store_i,
    input  logic [63:0] srcb_i,
    input  logic [63:0] rdata_i,
    output logic [7:0]  strobe_o,
    output logic [63:0] wdata_o,
    output logic [63:0] load_o
);

    logic [7:0]  mask;
    logic [63:0] sh;

    always_comb begin
        case (funct3_i[1:0])
            2'd0:    mask = 8'h01;
            2'd1:    mask = 8'h03;
            2'd2:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        strobe_o = is_store_i ? (mask << off_i) : 8'h00;
        wdata_o  = srcb_i << {off_i, 3'b000};
        sh       = rdata_i >> {off_i, 3'b000};
        case (funct3_i)
            3'b000:  load_o = {{56{sh[7]}}, sh[7:0]};
            3'b001:  load_o = {{48{sh[15]}}, sh[15:0]};
            3'b010:  load_o = {{32{sh[31]}}, sh[31:0]};
            3'b100:  load_o = {56'b0, sh[7:0]};
            3'b101:  load_o = {48'b0, sh[15:0]};
            3'b110:  load_o = {32'b0, sh[31:0]};
            default: load_o = sh;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// RV64I MEM stage: one instruction in flight, split addr_ok/data_ok bus
// handshake, registered result toward writeback.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  execute_data_t     in,
    output logic              in_ready,
    output memory_data_t      out,
    input  logic              out_ready,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [7:0]        dreq_strobe,
    output logic [63:0]       dreq_wdata,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [63:0]       dresp_rdata
);

    mstate_t       state_q, state_d;
    execute_data_t r_q, r_d;
    u64            rd_q, rd_d;

    logic accept;
    logic in_goes_req;
    logic r_is_load;
    logic r_is_store;
    u64   load_data;

    assign accept      = in.valid & in_ready;
    assign in_goes_req = (in.ctl.memRw != MemNone) &
                         ~is_misaligned(in.alu_out[2:0], in.ctl.memSize[1:0]);
    assign r_is_load   = r_q.ctl.memRw == MemLoad;
    assign r_is_store  = r_q.ctl.memRw == MemStore;

    memory_stage_mem_align u_align (
        .off_i      (r_q.alu_out[2:0]),
        .funct3_i   (r_q.ctl.memSize),
        .is_store_i (r_is_store),
        .srcb_i     (r_q.srcb),
        .rdata_i    (dresp_rdata),
        .strobe_o   (dreq_strobe),
        .wdata_o    (dreq_wdata),
        .load_o     (load_data)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        rd_d    = rd_q;
        unique case (state_q)
            StReq: begin
                if (dresp_data_ok) rd_d = r_is_load ? load_data : '0;
                if (dresp_addr_ok) state_d = dresp_data_ok ? StFull : StWait;
            end
            StWait: begin
                if (dresp_data_ok) begin
                    rd_d    = r_is_load ? load_data : '0;
                    state_d = StFull;
                end
            end
            StFull: begin
                if (out_ready) state_d = StEmpty;
            end
            default: ;
        endcase
        // A new accept from FULL overrides the drain, so there is no bubble.
        if (accept) begin
            r_d     = in;
            rd_d    = '0;
            state_d = in_goes_req ? StReq : StFull;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StEmpty;
            r_q     <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            rd_q    <= rd_d;
        end
    end

    assign in_ready   = (state_q == StEmpty) | ((state_q == StFull) & out_ready);
    assign dreq_valid = state_q == StReq;
    assign dreq_addr  = r_q.alu_out[ADDR_W-1:0];
    assign dreq_size  = {1'b0, r_q.ctl.memSize[1:0]};

    always_comb begin
        out         = '0;
        out.valid   = (state_q == StFull) & r_q.valid;
        out.pc      = r_q.pc;
        out.alu_out = r_q.alu_out;
        out.rd      = rd_q;
        out.sextimm = r_q.sextimm;
        out.target  = r_q.target;
        out.dst     = r_q.dst;
        out.ctl     = r_q.ctl;
    end

endmodule
